// File: rtl/mux_tree_reg.sv
// N:1 word selector built from 4:1 stages (select bit pairs from the LSB) with a final
// 2:1 stage when the select width is odd; selected word is also captured on in_valid.
module mux_tree_reg #(
  parameter  int unsigned N_INPUTS = 8,
  parameter  int unsigned WIDTH    = 1,
  localparam int unsigned SEL_W    = $clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_INPUTS*WIDTH-1:0] in_vec,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      in_valid,
  output logic [WIDTH-1:0]          comb_out,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid
);

  localparam int unsigned N4     = SEL_W / 2;
  localparam bit          ODD    = (SEL_W % 2) == 1;
  localparam int unsigned LEAVES = 1 << SEL_W;

  function automatic logic [WIDTH-1:0] mux4(input logic [WIDTH-1:0] a0,
                                            input logic [WIDTH-1:0] a1,
                                            input logic [WIDTH-1:0] a2,
                                            input logic [WIDTH-1:0] a3,
                                            input logic [1:0]       s);
    logic [WIDTH-1:0] r;
    r = '0;
    case (s)
      2'd0: r = a0;
      2'd1: r = a1;
      2'd2: r = a2;
      2'd3: r = a3;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] mux2(input logic [WIDTH-1:0] a0,
                                            input logic [WIDTH-1:0] a1,
                                            input logic             s);
    logic [WIDTH-1:0] r;
    r = '0;
    case (s)
      1'b0: r = a0;
      1'b1: r = a1;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Level 0 holds the leaves padded to a power of two; out-of-range selects land on zeros.
  for (genvar l = 0; l <= N4; l++) begin : g_lvl
    localparam int unsigned CNT = LEAVES >> (2 * l);
    logic [WIDTH-1:0] w [CNT];
    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < CNT; k++) begin : g_k
        if (k < N_INPUTS) begin : g_used
          assign w[k] = in_vec[k*WIDTH +: WIDTH];
        end else begin : g_pad
          assign w[k] = '0;
        end
      end
    end else begin : g_mux
      for (genvar k = 0; k < CNT; k++) begin : g_k
        assign w[k] = mux4(g_lvl[l-1].w[4*k],   g_lvl[l-1].w[4*k+1],
                           g_lvl[l-1].w[4*k+2], g_lvl[l-1].w[4*k+3],
                           sel[2*(l-1) +: 2]);
      end
    end
  end

  if (ODD) begin : g_root2
    assign comb_out = mux2(g_lvl[N4].w[0], g_lvl[N4].w[1], sel[SEL_W-1]);
  end else begin : g_root4
    assign comb_out = g_lvl[N4].w[0];
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q;

  always_comb begin
    out_d = out_q;
    if (in_valid) out_d = comb_out;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= in_valid;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_tree_reg.sv
// Bench for mux_tree_reg: exhaustive/random combinational sweeps on several sizes and a
// scoreboarded registered path on the 8x8 instance.
module tb_mux_tree_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // 8 x 1
  logic [7:0]  a_vec = '0;
  logic [2:0]  a_sel = '0;
  logic        a_iv  = 1'b0;
  logic [0:0]  a_co, a_o;
  logic        a_ov;
  // 8 x 8 (registered path under test)
  logic [63:0] b_vec = '0;
  logic [2:0]  b_sel = '0;
  logic        b_iv  = 1'b0;
  logic [7:0]  b_co, b_o;
  logic        b_ov;
  // 6 x 4
  logic [23:0] c_vec = '0;
  logic [2:0]  c_sel = '0;
  logic        c_iv  = 1'b0;
  logic [3:0]  c_co, c_o;
  logic        c_ov;
  // 2 x 1
  logic [1:0]  d_vec = '0;
  logic [0:0]  d_sel = '0;
  logic        d_iv  = 1'b0;
  logic [0:0]  d_co, d_o;
  logic        d_ov;
  // 4 x 1
  logic [3:0]  e_vec = '0;
  logic [1:0]  e_sel = '0;
  logic        e_iv  = 1'b0;
  logic [0:0]  e_co, e_o;
  logic        e_ov;

  mux_tree_reg #(.N_INPUTS(8), .WIDTH(1)) u_a (
    .clk(clk), .reset_n(rst_n), .in_vec(a_vec), .sel(a_sel), .in_valid(a_iv),
    .comb_out(a_co), .out(a_o), .out_valid(a_ov));
  mux_tree_reg #(.N_INPUTS(8), .WIDTH(8)) u_b (
    .clk(clk), .reset_n(rst_n), .in_vec(b_vec), .sel(b_sel), .in_valid(b_iv),
    .comb_out(b_co), .out(b_o), .out_valid(b_ov));
  mux_tree_reg #(.N_INPUTS(6), .WIDTH(4)) u_c (
    .clk(clk), .reset_n(rst_n), .in_vec(c_vec), .sel(c_sel), .in_valid(c_iv),
    .comb_out(c_co), .out(c_o), .out_valid(c_ov));
  mux_tree_reg #(.N_INPUTS(2), .WIDTH(1)) u_d (
    .clk(clk), .reset_n(rst_n), .in_vec(d_vec), .sel(d_sel), .in_valid(d_iv),
    .comb_out(d_co), .out(d_o), .out_valid(d_ov));
  mux_tree_reg #(.N_INPUTS(4), .WIDTH(1)) u_e (
    .clk(clk), .reset_n(rst_n), .in_vec(e_vec), .sel(e_sel), .in_valid(e_iv),
    .comb_out(e_co), .out(e_o), .out_valid(e_ov));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word selection from first principles: shift the chosen word down and mask it.
  function automatic logic [31:0] ref_sel(input logic [255:0] vec, input int unsigned s,
                                          input int unsigned n, input int unsigned w);
    logic [255:0] sh;
    if (s >= n) return '0;
    sh = vec >> (s * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

  // Scoreboard for the registered 8x8 output.
  logic [7:0] sb_q [$];
  logic [7:0] held = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      held = '0;
      chk("rst_out", 32'(b_o), 32'd0);
      chk("rst_out_valid", 32'(b_ov), 32'd0);
    end else if (b_ov) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        held = sb_q.pop_front();
        chk("reg_out", 32'(b_o), 32'(held));
      end
    end else begin
      chk("reg_hold", 32'(b_o), 32'(held));
    end
  end

  task automatic drive_b(input logic [63:0] v, input logic [2:0] s, input logic iv);
    @(posedge clk);
    #1;
    b_vec = v;
    b_sel = s;
    b_iv  = iv;
    if (iv) sb_q.push_back(8'(ref_sel(256'(v), s, 8, 8)));
    #1;
    chk("b_comb", 32'(b_co), ref_sel(256'(v), s, 8, 8));
  endtask

  logic [63:0] words10;
  logic [10:0] sv;
  logic [5:0]  ev;
  logic [3:0]  xv;

  initial begin
    for (int unsigned k = 0; k < 8; k++) words10[k*8 +: 8] = 8'(8'h10 + k);

    #22;
    rst_n = 1'b1;

    // 8x1: every {sel, word0..word7} with word0 as MSB of the 8-bit word field.
    for (int unsigned v = 0; v < 2048; v++) begin
      sv = 11'(v);
      a_sel = sv[10:8];
      for (int unsigned k = 0; k < 8; k++) a_vec[k] = sv[7-k];
      #1;
      chk("a_comb", 32'(a_co), ref_sel(256'(a_vec), a_sel, 8, 1));
    end
    a_sel = 3'b101; a_vec = 8'b0010_0000; #1;
    chk("a_sel5_word5", 32'(a_co), 32'd1);

    // 2x1 and 4x1: exhaustive sweeps.
    for (int unsigned v = 0; v < 8; v++) begin
      d_sel = 1'(v >> 2);
      d_vec = 2'(v);
      #1;
      chk("d_comb", 32'(d_co), ref_sel(256'(d_vec), d_sel, 2, 1));
    end
    for (int unsigned v = 0; v < 64; v++) begin
      ev = 6'(v);
      e_sel = ev[5:4];
      e_vec = ev[3:0];
      #1;
      chk("e_comb", 32'(e_co), ref_sel(256'(e_vec), e_sel, 4, 1));
    end
    // Unselected inputs unknown: result must still be the selected bit, never X.
    for (int unsigned v = 0; v < 8; v++) begin
      xv = 'x;
      e_sel = 2'(v >> 1);
      xv[e_sel] = 1'(v);
      e_vec = xv;
      #1;
      chk("e_no_x", 32'($isunknown(e_co)), 32'd0);
      chk("e_x_sel", 32'(e_co), 32'(v & 1));
    end

    // 6x4: out-of-range selects, word 5, then random sweep.
    c_vec = 24'hFFFFFF;
    c_sel = 3'd6; #1; chk("c_sel6_zero", 32'(c_co), 32'd0);
    c_sel = 3'd7; #1; chk("c_sel7_zero", 32'(c_co), 32'd0);
    c_vec = 24'h0A_0000 | 24'h012345; c_vec[23:20] = 4'hA;
    c_sel = 3'd5; #1; chk("c_sel5", 32'(c_co), 32'hA);
    for (int unsigned i = 0; i < 200; i++) begin
      c_vec = 24'($urandom);
      c_sel = 3'($urandom_range(0, 7));
      #1;
      chk("c_comb", 32'(c_co), ref_sel(256'(c_vec), c_sel, 6, 4));
    end

    // 8x8 registered path: capture, then hold while sel moves.
    drive_b(words10, 3'd6, 1'b1);
    chk("b_comb_0x16", 32'(b_co), 32'h16);
    drive_b(words10, 3'd2, 1'b0);
    chk("b_comb_0x12", 32'(b_co), 32'h12);
    drive_b(words10, 3'd2, 1'b0);
    chk("b_hold_0x16", 32'(b_o), 32'h16);

    // Random mix of captures and idles.
    for (int unsigned i = 0; i < 300; i++)
      drive_b({$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

    // Asynchronous reset between edges after capturing 0x16.
    drive_b(words10, 3'd6, 1'b1);
    drive_b(words10, 3'd6, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_out", 32'(b_o), 32'h16);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(b_o), 32'd0);
    chk("async_rst_valid", 32'(b_ov), 32'd0);
    // Capture request while reset is held is discarded.
    b_iv = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wins_out", 32'(b_o), 32'd0);
    chk("rst_wins_valid", 32'(b_ov), 32'd0);
    b_iv = 1'b0;
    #1;
    rst_n = 1'b1;
    drive_b(words10, 3'd1, 1'b1);
    drive_b(words10, 3'd1, 1'b0);
    chk("post_rst_out_0x11", 32'(b_o), 32'h11);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
